// File: rtl/imem_pkg.sv
// imem_pkg: shared types and constants for the instruction-memory loader.
// Used by byte_packer and imem_loader.
package imem_pkg;

   localparam int IMEM_ADDR_W = 12;
   localparam int IMEM_WORD_W = 32;

   typedef enum logic [2:0] {
      IDLE,
      LEN0,
      LEN1,
      DATA,
      WRITE,
      CHK,
      DONE,
      ERROR
   } state_t;

   // States in which a stream byte may be taken
   function automatic logic takes_byte(state_t s);
      return (s == LEN0) || (s == LEN1) ||
             (s == DATA) || (s == CHK);
   endfunction

endpackage

// File: rtl/byte_packer.sv
// byte_packer: little-endian byte-lane assembler for 32-bit words.
// Flags the cycle in which the fourth byte of a word arrives.
module byte_packer
   import imem_pkg::*;
(
   input  logic                   clk_in,
   input  logic                   rst_n_in,
   input  logic                   clr_in,
   input  logic                   shift_in,
   input  logic [7:0]             byte_in,
   output logic [IMEM_WORD_W-1:0] word_out,
   output logic                   full_out
);

   logic [1:0]  idx_q;
   logic [23:0] lanes_q;

   assign full_out = shift_in && (idx_q == 2'd3);

   // Place each byte in its lane; the fourth byte publishes the word
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         idx_q    <= '0;
         lanes_q  <= '0;
         word_out <= '0;
      end else if (clr_in) begin
         idx_q <= '0;
      end else if (shift_in) begin
         idx_q <= idx_q + 2'd1;
         unique case (idx_q)
            2'd0: lanes_q[7:0]   <= byte_in;
            2'd1: lanes_q[15:8]  <= byte_in;
            2'd2: lanes_q[23:16] <= byte_in;
            2'd3: word_out       <= {byte_in, lanes_q};
         endcase
      end
   end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: boot loader that streams an image into instruction memory.
// Optional trailing checksum byte: define IMEM_LOADER_CHECKSUM_EN.
module imem_loader
   import imem_pkg::*;
#(
   parameter int ADDR_W      = IMEM_ADDR_W,
   parameter int TIMEOUT_CYC = 1000000
) (
   input  logic                   clk_in,
   input  logic                   rst_n_in,
   input  logic                   start_in,
   input  logic                   byte_valid_in,
   input  logic [7:0]             byte_data_in,
   output logic                   byte_ready_out,
   output logic                   we_out,
   output logic [ADDR_W-1:0]      address_out,
   output logic [IMEM_WORD_W-1:0] data_out,
   output logic                   core_rst_n_out,
   output logic                   busy_out,
   output logic                   done_out,
   output logic                   error_out,
   output logic [ADDR_W:0]        word_cnt_out
);

   localparam int TW = (TIMEOUT_CYC > 1) ?
                       $clog2(TIMEOUT_CYC + 1) : 1;
   localparam logic [TW-1:0] TMO_LAST =
      (TIMEOUT_CYC > 0) ? TW'(TIMEOUT_CYC - 1) : '0;
   localparam logic [16:0] MAX_LEN = 17'd1 << ADDR_W;

   state_t state_q;
   state_t state_d;

   logic [7:0]             len_lo_q;
   logic [15:0]            len_q;
   logic [15:0]            n_in;
   logic [ADDR_W:0]        cnt_q;
   logic [ADDR_W:0]        cnt_inc;
   logic [ADDR_W-1:0]      addr_q;
   logic [TW-1:0]          tmo_q;
   logic                   take;
   logic                   acc;
   logic                   clr;
   logic                   bad_len;
   logic                   last_wr;
   logic                   tmo_hit;
   logic                   pk_clr;
   logic                   pk_shift;
   logic                   pk_full;
   logic [IMEM_WORD_W-1:0] pk_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0]             sum_q;
`endif

   assign take     = takes_byte(state_q);
   assign acc      = byte_valid_in && take;
   assign n_in     = {byte_data_in, len_lo_q};
   assign bad_len  = (n_in == 16'd0) ||
                     ({1'b0, n_in} > MAX_LEN);
   assign cnt_inc  = cnt_q + 1'b1;
   assign last_wr  = (32'(cnt_inc) == 32'(len_q));
   assign tmo_hit  = (TIMEOUT_CYC != 0) && take &&
                     !acc && (tmo_q == TMO_LAST);
   assign clr      = start_in &&
                     (state_q inside {IDLE, DONE, ERROR});
   assign pk_clr   = clr || ((state_q == LEN1) && acc);
   assign pk_shift = acc && (state_q == DATA);

   byte_packer u_pack (
      .clk_in   (clk_in),
      .rst_n_in (rst_n_in),
      .clr_in   (pk_clr),
      .shift_in (pk_shift),
      .byte_in  (byte_data_in),
      .word_out (pk_word),
      .full_out (pk_full)
   );

   // State register
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) state_q <= IDLE;
      else           state_q <= state_d;
   end

   // Session sequencing; a stall timeout aborts any byte-taking state
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE, DONE, ERROR: begin
            if (clr) state_d = LEN0;
         end
         LEN0: begin
            if (acc)          state_d = LEN1;
            else if (tmo_hit) state_d = ERROR;
         end
         LEN1: begin
            if (acc)          state_d = bad_len ? ERROR : DATA;
            else if (tmo_hit) state_d = ERROR;
         end
         DATA: begin
            if (pk_full)      state_d = WRITE;
            else if (tmo_hit) state_d = ERROR;
         end
         WRITE: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state_d = last_wr ? CHK : DATA;
`else
            state_d = last_wr ? DONE : DATA;
`endif
         end
         CHK: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            if (acc)
               state_d = (byte_data_in == sum_q) ? DONE : ERROR;
            else if (tmo_hit)
               state_d = ERROR;
`else
            state_d = ERROR;
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   // Capture the two length bytes
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         len_lo_q <= '0;
         len_q    <= '0;
      end else begin
         if ((state_q == LEN0) && acc) len_lo_q <= byte_data_in;
         if ((state_q == LEN1) && acc) len_q    <= n_in;
      end
   end

   // Word counter, and an address latched only when a word completes
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         cnt_q  <= '0;
         addr_q <= '0;
      end else if (clr) begin
         cnt_q  <= '0;
         addr_q <= '0;
      end else begin
         if (pk_full)            addr_q <= cnt_q[ADDR_W-1:0];
         if (state_q == WRITE)   cnt_q  <= cnt_inc;
      end
   end

   // Idle-cycle counter, restarted by any byte or state change
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in)
         tmo_q <= '0;
      else if ((TIMEOUT_CYC == 0) || acc || !take ||
               (state_d != state_q))
         tmo_q <= '0;
      else
         tmo_q <= tmo_q + 1'b1;
   end

`ifdef IMEM_LOADER_CHECKSUM_EN
   // Running modulo-256 sum over length and data bytes
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in)
         sum_q <= '0;
      else if (clr)
         sum_q <= '0;
      else if (acc && (state_q != CHK))
         sum_q <= sum_q + byte_data_in;
   end
`endif

   assign byte_ready_out = take;
   assign we_out         = (state_q == WRITE);
   assign address_out    = addr_q;
   assign data_out       = pk_word;
   assign busy_out       = take || (state_q == WRITE);
   assign done_out       = (state_q == DONE);
   assign error_out      = (state_q == ERROR);
   assign core_rst_n_out = (state_q == DONE);
   assign word_cnt_out   = cnt_q;

endmodule
